ddr3_cmd_sched: RTL and testbench

DDR3_CMD_SCHED -- requirements
Module: ddr3_cmd_sched

---
 rtl/ddr3_cmd_sched.sv | 197 +++++++++++++++++++
 tb/tb_ddr3_cmd_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: per-bank open-row tracking, ACT/PRE/RD/WR timing and periodic refresh.
// Defining DDR3_AUTO_PRECHARGE_EN selects closed-page (auto-precharge) policy; open-page otherwise.
module ddr3_cmd_sched #(
  parameter int T_RCD  = 5,
  parameter int T_RP   = 5,
  parameter int T_CCD  = 4,
  parameter int T_RFC  = 44,
  parameter int T_REFI = 780
) (
  input  logic        CPU_CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [2:0]  BA,
  output logic [14:0] MEM_ADDR,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, PRE, ACT, RW, REFPRE, REF, WAIT} state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

`ifdef DDR3_AUTO_PRECHARGE_EN
  localparam int   RW_GAP   = T_CCD + T_RP - 1;
  localparam logic AUTO_PRE = 1'b1;
`else
  localparam int   RW_GAP   = T_CCD - 1;
  localparam logic AUTO_PRE = 1'b0;
`endif

  // RW gap is one short of T_CCD: the IDLE cycle is the accept cycle of the next hit.
  localparam logic [7:0]  GAP_RCD  = 8'(T_RCD);
  localparam logic [7:0]  GAP_RP   = 8'(T_RP);
  localparam logic [7:0]  GAP_RFC  = 8'(T_RFC);
  localparam logic [7:0]  GAP_RW   = 8'(RW_GAP);
  localparam logic [15:0] REFI_TOP = 16'(T_REFI - 1);

  state_t      state, state_n, ret_state, ret_n;
  logic [7:0]  wait_cnt, wait_n, gap;
  logic        go, clr_pend;
  logic [15:0] ref_cnt;
  logic        ref_pending, refreshing;
  logic [7:0]  bank_open;
  logic [14:0] bank_row [8];

  logic        req_we;
  logic [2:0]  req_bank;
  logic [14:0] req_row;
  logic [9:0]  req_col;

  logic [2:0]  in_bank;
  logic [14:0] in_row;
  logic [9:0]  in_col;
  logic        accept, hit;
  logic [3:0]  cmd;
  logic        unused_addr;

  assign in_bank     = REQ_ADDR[15:13];
  assign in_row      = REQ_ADDR[30:16];
  assign in_col      = REQ_ADDR[12:3];
  assign unused_addr = ^{REQ_ADDR[31], REQ_ADDR[2:0]};

  assign REQ_READY = (state == IDLE) && !ref_pending && !RESET;
  assign accept    = REQ_VALID && REQ_READY;
  assign hit       = bank_open[in_bank] && (bank_row[in_bank] == in_row);

  always_comb begin
    state_n  = state;
    ret_n    = ret_state;
    wait_n   = wait_cnt;
    gap      = '0;
    go       = 1'b0;
    clr_pend = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pending)
          state_n = (|bank_open) ? REFPRE : REF;
        else if (accept)
          state_n = hit ? RW : (bank_open[in_bank] ? PRE : ACT);
      end
      PRE:    begin go = 1'b1; gap = GAP_RP;  ret_n = ACT;  end
      ACT:    begin go = 1'b1; gap = GAP_RCD; ret_n = RW;   end
      RW:     begin go = 1'b1; gap = GAP_RW;  ret_n = IDLE; end
      REFPRE: begin go = 1'b1; gap = GAP_RP;  ret_n = REF;  end
      REF: begin
        go       = 1'b1;
        gap      = GAP_RFC;
        ret_n    = IDLE;
        clr_pend = (GAP_RFC <= 8'd1);
      end
      WAIT: begin
        if (wait_cnt <= 8'd1) begin
          state_n  = ret_state;
          clr_pend = refreshing;
        end else begin
          wait_n = wait_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A gap of one cycle (or none) goes straight to the follow-on state.
    if (go) begin
      if (gap <= 8'd1) begin
        state_n = ret_n;
      end else begin
        state_n = WAIT;
        wait_n  = gap - 8'd1;
      end
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      wait_cnt    <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      refreshing  <= 1'b0;
      bank_open   <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      wait_cnt  <= wait_n;
      if (ref_cnt == REFI_TOP) ref_cnt <= '0;
      else                     ref_cnt <= ref_cnt + 16'd1;
      // A wrap landing on the clear cycle keeps the new refresh request.
      if (ref_cnt == REFI_TOP) ref_pending <= 1'b1;
      else if (clr_pend)       ref_pending <= 1'b0;
      if (state == REF)        refreshing <= 1'b1;
      else if (clr_pend)       refreshing <= 1'b0;
      case (state)
        ACT:     bank_open[req_bank] <= 1'b1;
        PRE:     bank_open[req_bank] <= 1'b0;
        RW:      if (AUTO_PRE) bank_open[req_bank] <= 1'b0;
        REF:     bank_open <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (state == ACT) bank_row[req_bank] <= req_row;
    if (accept) begin
      req_we   <= REQ_WE;
      req_bank <= in_bank;
      req_row  <= in_row;
      req_col  <= in_col;
    end
  end

  always_comb begin
    cmd      = CMD_NOP;
    BA       = '0;
    MEM_ADDR = '0;
    DONE     = 1'b0;
    if (!RESET) begin
      case (state)
        PRE: begin
          cmd = CMD_PRE;
          BA  = req_bank;
        end
        ACT: begin
          cmd      = CMD_ACT;
          BA       = req_bank;
          MEM_ADDR = req_row;
        end
        RW: begin
          cmd      = req_we ? CMD_WR : CMD_RD;
          BA       = req_bank;
          MEM_ADDR = {4'b0000, AUTO_PRE, req_col};
          DONE     = 1'b1;
        end
        REFPRE: begin
          cmd      = CMD_PRE;
          MEM_ADDR = 15'h0400;
        end
        REF:     cmd = CMD_REF;
        default: ;
      endcase
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd;

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Randomized bench for ddr3_cmd_sched against a transaction-level command schedule model.
module tb_ddr3_cmd_sched;

  localparam int T_RCD  = 5;
  localparam int T_RP   = 5;
  localparam int T_CCD  = 4;
  localparam int T_RFC  = 44;
  localparam int T_REFI = 780;
  localparam int NCYC   = 4000;
  localparam int RST_AT = 1501;

  localparam int NOP  = 'b0111;
  localparam int ACTC = 'b0011;
  localparam int RDC  = 'b0101;
  localparam int WRC  = 'b0100;
  localparam int PREC = 'b0010;
  localparam int REFC = 'b0001;

`ifdef DDR3_AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, we;
  logic [31:0] addr;
  logic        ready, cs_n, ras_n, cas_n, we_n, done;
  logic [2:0]  ba;
  logic [14:0] mem_addr;

  ddr3_cmd_sched #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_CCD(T_CCD), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .CPU_CLK(clk), .RESET(rst), .REQ_VALID(valid), .REQ_READY(ready),
    .REQ_WE(we), .REQ_ADDR(addr), .CS_N(cs_n), .RAS_N(ras_n), .CAS_N(cas_n),
    .WE_N(we_n), .BA(ba), .MEM_ADDR(mem_addr), .DONE(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input int t, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, t, got, exp);
    end
  endtask

  // Expected command schedule keyed by cycle; absent cycles expect NOP.
  int e_cmd  [int];
  int e_ba   [int];
  int e_addr [int];
  int e_mask [int];

  bit m_open [8];
  int m_row  [8];
  int ready_at, ref_cnt, pend_clr_at;
  bit pend;

  task automatic plan(input int c, input int cm, input int b, input int a, input int m);
    e_cmd[c]  = cm;
    e_ba[c]   = b;
    e_addr[c] = a;
    e_mask[c] = m;
  endtask

  task automatic model_reset(input int first_cycle);
    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
    pend        = 1'b0;
    ref_cnt     = 0;
    ready_at    = first_cycle;
    pend_clr_at = -1;
    e_cmd.delete();
    e_ba.delete();
    e_addr.delete();
    e_mask.delete();
  endtask

  initial begin
    int cur_b, cur_r, cur_col, cur_we, sel, c, exp_c, exp_rdy, rw_gap;
    bit any_open;

    rst   = 1'b1;
    valid = 1'b0;
    we    = 1'b0;
    addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_cmd",   -1, {cs_n, ras_n, cas_n, we_n}, NOP);
    chk_eq("rst_ready", -1, ready, 0);
    chk_eq("rst_done",  -1, done, 0);
    chk_eq("rst_ba",    -1, ba, 0);
    chk_eq("rst_addr",  -1, mem_addr, 0);
    @(posedge clk);
    #1;
    model_reset(0);

    for (int t = 0; t < NCYC; t++) begin
      rst     = (t == RST_AT);
      cur_b   = $urandom_range(0, 3);
      sel     = $urandom_range(0, 2);
      cur_r   = (sel == 0) ? 'h10 : (sel == 1) ? 'h20 : $urandom_range(0, 32767);
      cur_col = $urandom_range(0, 1023);
      cur_we  = $urandom_range(0, 1);
      if (rst || (t >= 2000 && t < 2900)) valid = 1'b0;
      else valid = ($urandom_range(0, 99) < 55);
      we   = cur_we[0];
      addr = {1'($urandom_range(0, 1)), 15'(cur_r), 3'(cur_b), 10'(cur_col),
              3'($urandom_range(0, 7))};

      @(negedge clk);
      exp_rdy = (!rst && t >= ready_at && !pend) ? 1 : 0;
      exp_c   = (!rst && e_cmd.exists(t)) ? e_cmd[t] : NOP;
      chk_eq("cmd",   t, {cs_n, ras_n, cas_n, we_n}, exp_c);
      chk_eq("ready", t, ready, exp_rdy);
      chk_eq("done",  t, done, (exp_c == RDC || exp_c == WRC) ? 1 : 0);
      if (rst) begin
        chk_eq("rst_ba",   t, ba, 0);
        chk_eq("rst_addr", t, mem_addr, 0);
      end else if (exp_c != NOP) begin
        if (e_ba[t] >= 0) chk_eq("ba", t, ba, e_ba[t]);
        if (e_mask[t] != 0) chk_eq("addr", t, int'(mem_addr) & e_mask[t], e_addr[t]);
      end

      if (rst) begin
        model_reset(t + 1);
      end else begin
        if (t >= ready_at && pend) begin
          c = t + 1;
          any_open = 1'b0;
          for (int i = 0; i < 8; i++) any_open |= m_open[i];
          if (any_open) begin
            plan(c, PREC, -1, 'h400, 'h400);
            c += T_RP;
          end
          plan(c, REFC, -1, 0, 0);
          for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
          ready_at    = c + T_RFC;
          pend_clr_at = c + T_RFC;
        end else if (t >= ready_at && valid) begin
          c = t + 1;
          if (!(m_open[cur_b] && m_row[cur_b] == cur_r)) begin
            if (m_open[cur_b]) begin
              plan(c, PREC, cur_b, 0, 'h400);
              c += T_RP;
            end
            plan(c, ACTC, cur_b, cur_r, 'h7fff);
            c += T_RCD;
            m_open[cur_b] = 1'b1;
            m_row[cur_b]  = cur_r;
          end
          plan(c, cur_we ? WRC : RDC, cur_b, cur_col | (AP ? 'h400 : 0), 'h7fff);
          if (AP) m_open[cur_b] = 1'b0;
          rw_gap   = AP ? (T_CCD + T_RP - 1) : (T_CCD - 1);
          ready_at = c + ((rw_gap < 1) ? 1 : rw_gap);
        end
        if (t + 1 == pend_clr_at) pend = 1'b0;
        if (ref_cnt == T_REFI - 1) begin
          ref_cnt = 0;
          pend    = 1'b1;
        end else begin
          ref_cnt++;
        end
      end

      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
